// File: rtl/rs_multi.sv
// Multi-queue reservation station: one age-ordered queue per FU with CDB wakeup,
// dispatch-time bypass, oldest-ready select and ROB-relative recovery squash.
package rs_multi_pkg;
  localparam int FU_NUM  = 3;
  localparam int PHYS_W  = 6;
  localparam int ROB_W   = 4;
  localparam int EPOCH_W = 2;

  typedef enum logic [1:0] {FU_ALU = 2'd0, FU_MUL = 2'd1, FU_MEM = 2'd2} fu_e;
  typedef enum logic [2:0] {
    UC_INT = 3'd0, UC_BRANCH = 3'd1, UC_MUL = 3'd2, UC_DIV = 3'd3, UC_LOAD = 3'd4, UC_STORE = 3'd5
  } uop_class_e;

  typedef struct packed {
    uop_class_e uop_class;
    logic [7:0] imm;
  } uop_bundle_t;

  typedef struct packed {
    uop_bundle_t        bundle;
    logic [ROB_W-1:0]   rob_idx;
    logic [EPOCH_W-1:0] epoch;
    logic [PHYS_W-1:0]  prd;
    logic [PHYS_W-1:0]  prs1;
    logic [PHYS_W-1:0]  prs2;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               rdy1;
    logic               rdy2;
  } rs_uop_t;

  function automatic fu_e uop_to_fu(input uop_class_e c);
    case (c)
      UC_MUL, UC_DIV:    return FU_MUL;
      UC_LOAD, UC_STORE: return FU_MEM;
      default:           return FU_ALU;
    endcase
  endfunction
endpackage

module rs_multi
  import rs_multi_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WB_PORTS = 2,
  localparam int AGE_W   = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  rs_uop_t                            disp_uop,
  input  logic [WB_PORTS-1:0]                wb_valid,
  input  logic [WB_PORTS-1:0][PHYS_W-1:0]    wb_pd,
  output logic [FU_NUM-1:0]                  issue_valid,
  input  logic [FU_NUM-1:0]                  issue_ready,
  output rs_uop_t [FU_NUM-1:0]               issue_uop,
  input  logic [ROB_W-1:0]                   rob_head,
  input  logic                               flush_valid,
  input  logic                               recover_valid,
  input  logic [ROB_W-1:0]                   recover_rob_idx,
  input  logic [EPOCH_W-1:0]                 recover_epoch,
  output logic                               busy,
  output logic [FU_NUM-1:0][AGE_W:0]         occupancy
);

  localparam logic [AGE_W:0] CNT_ONE  = (AGE_W+1)'(1);
  localparam logic [AGE_W:0] CNT_FULL = (AGE_W+1)'(DEPTH);

  function automatic logic wb_hit(input logic [PHYS_W-1:0] pr,
                                  input logic [WB_PORTS-1:0] v,
                                  input logic [WB_PORTS-1:0][PHYS_W-1:0] pd);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++)
      if (v[p] && (pd[p] == pr)) hit = 1'b1;
    return hit;
  endfunction

  // Distance from the ROB head, so age order survives index wrap.
  function automatic logic [ROB_W-1:0] rob_rel(input logic [ROB_W-1:0] x,
                                               input logic [ROB_W-1:0] head);
    return x - head;
  endfunction

  fu_e               disp_fu;
  rs_uop_t           disp_entry;
  logic              disp_fire;
  logic [FU_NUM-1:0] fu_busy;

  assign disp_fu    = uop_to_fu(disp_uop.bundle.uop_class);
  assign disp_ready = !flush_valid && !recover_valid && (occupancy[disp_fu] != CNT_FULL);
  assign disp_fire  = disp_valid && disp_ready;
  assign busy       = |fu_busy;

  always_comb begin
    disp_entry      = disp_uop;
    disp_entry.rdy1 = disp_uop.rdy1 || !disp_uop.uses_rs1 || wb_hit(disp_uop.prs1, wb_valid, wb_pd);
    disp_entry.rdy2 = disp_uop.rdy2 || !disp_uop.uses_rs2 || wb_hit(disp_uop.prs2, wb_valid, wb_pd);
  end

  genvar gi;
  for (gi = 0; gi < FU_NUM; gi++) begin : g_fu
    logic [DEPTH-1:0] valid_q, valid_d;
    rs_uop_t          uop_q [DEPTH];
    rs_uop_t          uop_d [DEPTH];
    logic [AGE_W-1:0] age_q [DEPTH];
    logic [AGE_W-1:0] age_d [DEPTH];
    logic [DEPTH-1:0] squash, ready, keep;
    logic             sel_found, fire, disp_here;
    logic [AGE_W-1:0] sel_idx, sel_age, free_idx;
    logic [AGE_W:0]   occ, keep_cnt;
    rs_uop_t          sel_uop;

    assign disp_here = disp_fire && (int'(disp_fu) == gi);

    always_comb begin
      squash = '0;
      ready  = '0;
      for (int e = 0; e < DEPTH; e++) begin
        squash[e] = recover_valid && valid_q[e] &&
                    ((rob_rel(uop_q[e].rob_idx, rob_head) > rob_rel(recover_rob_idx, rob_head)) ||
                     (uop_q[e].epoch != recover_epoch));
        ready[e]  = valid_q[e] && !squash[e] &&
                    (!uop_q[e].uses_rs1 || uop_q[e].rdy1) &&
                    (!uop_q[e].uses_rs2 || uop_q[e].rdy2);
      end
    end

    always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (ready[e] && (!sel_found || (age_q[e] < sel_age))) begin
          sel_found = 1'b1;
          sel_idx   = AGE_W'(e);
          sel_age   = age_q[e];
        end
      end
      sel_uop      = uop_q[sel_idx];
      sel_uop.rdy1 = 1'b1;
      sel_uop.rdy2 = 1'b1;
    end

    assign fire = sel_found && issue_ready[gi];

    always_comb begin
      keep     = '0;
      occ      = '0;
      free_idx = '0;
      for (int e = 0; e < DEPTH; e++) begin
        keep[e] = valid_q[e] && !squash[e] && !(fire && (sel_idx == AGE_W'(e)));
        if (valid_q[e]) occ = occ + CNT_ONE;
      end
      // Search from the top so the lowest free index wins.
      for (int e = DEPTH - 1; e >= 0; e--)
        if (!valid_q[e]) free_idx = AGE_W'(e);
    end

    always_comb begin
      logic [AGE_W:0] older;
      older    = '0;
      valid_d  = valid_q;
      uop_d    = uop_q;
      age_d    = age_q;
      keep_cnt = '0;
      for (int e = 0; e < DEPTH; e++) begin
        // New age = number of surviving entries that were older; covers issue and squash.
        older = '0;
        for (int j = 0; j < DEPTH; j++)
          if (keep[j] && (age_q[j] < age_q[e])) older = older + CNT_ONE;
        valid_d[e] = keep[e];
        age_d[e]   = older[AGE_W-1:0];
        if (wb_hit(uop_q[e].prs1, wb_valid, wb_pd)) uop_d[e].rdy1 = 1'b1;
        if (wb_hit(uop_q[e].prs2, wb_valid, wb_pd)) uop_d[e].rdy2 = 1'b1;
        if (keep[e]) keep_cnt = keep_cnt + CNT_ONE;
      end
      if (disp_here) begin
        valid_d[free_idx] = 1'b1;
        uop_d[free_idx]   = disp_entry;
        age_d[free_idx]   = keep_cnt[AGE_W-1:0];
      end
      if (flush_valid) begin
        valid_d = '0;
        for (int e = 0; e < DEPTH; e++) age_d[e] = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        for (int e = 0; e < DEPTH; e++) age_q[e] <= '0;
      end else begin
        valid_q <= valid_d;
        age_q   <= age_d;
      end
    end

    // Payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
      uop_q <= uop_d;
    end

    assign issue_valid[gi] = sel_found;
    assign issue_uop[gi]   = sel_uop;
    assign occupancy[gi]   = occ;
    assign fu_busy[gi]     = |valid_q;
  end

endmodule

// File: tb/tb_rs_multi.sv
// Bench for rs_multi: directed scenarios plus random traffic, all checked against
// an ordered-list model of each FU queue (oldest first).
`timescale 1ns/1ps
module tb_rs_multi;
  import rs_multi_pkg::*;

  localparam int DEPTH    = 4;
  localparam int WB_PORTS = 2;
  localparam int AGE_W    = $clog2(DEPTH);
  localparam int ALU      = 0;
  localparam int MUL      = 1;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            disp_valid;
  logic                            disp_ready;
  rs_uop_t                         disp_uop;
  logic [WB_PORTS-1:0]             wb_valid;
  logic [WB_PORTS-1:0][PHYS_W-1:0] wb_pd;
  logic [FU_NUM-1:0]               issue_valid;
  logic [FU_NUM-1:0]               issue_ready;
  rs_uop_t [FU_NUM-1:0]            issue_uop;
  logic [ROB_W-1:0]                rob_head;
  logic                            flush_valid;
  logic                            recover_valid;
  logic [ROB_W-1:0]                recover_rob_idx;
  logic [EPOCH_W-1:0]              recover_epoch;
  logic                            busy;
  logic [FU_NUM-1:0][AGE_W:0]      occupancy;

  always #5 clk = ~clk;

  rs_multi #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_uop(disp_uop),
    .wb_valid(wb_valid), .wb_pd(wb_pd),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_uop(issue_uop),
    .rob_head(rob_head), .flush_valid(flush_valid), .recover_valid(recover_valid),
    .recover_rob_idx(recover_rob_idx), .recover_epoch(recover_epoch),
    .busy(busy), .occupancy(occupancy)
  );

  int total = 0;
  int bad   = 0;
  rs_uop_t mq [FU_NUM][$];
  logic [EPOCH_W-1:0] cur_epoch = '0;
  logic [ROB_W-1:0]   rob_ctr   = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [PHYS_W-1:0] pr);
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p] && (wb_pd[p] == pr)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic is_ready(input rs_uop_t u);
    return (!u.uses_rs1 || u.rdy1) && (!u.uses_rs2 || u.rdy2);
  endfunction

  function automatic logic squashed(input rs_uop_t u);
    logic [ROB_W-1:0] dist_u, dist_r;
    dist_u = u.rob_idx - rob_head;
    dist_r = recover_rob_idx - rob_head;
    return recover_valid && ((dist_u > dist_r) || (u.epoch != recover_epoch));
  endfunction

  function automatic rs_uop_t mk(input int cls, input int rob, input int p1, input logic r1,
                                 input int p2, input logic r2);
    rs_uop_t u;
    u                  = '0;
    u.bundle.uop_class = uop_class_e'(cls);
    u.bundle.imm       = 8'(rob);
    u.rob_idx          = ROB_W'(rob);
    u.epoch            = cur_epoch;
    u.prd              = PHYS_W'(rob + 32);
    u.prs1             = PHYS_W'(p1);
    u.prs2             = PHYS_W'(p2);
    u.uses_rs1         = 1'b1;
    u.uses_rs2         = 1'b1;
    u.rdy1             = r1;
    u.rdy2             = r2;
    return u;
  endfunction

  task automatic idle();
    disp_valid      = 1'b0;
    disp_uop        = '0;
    wb_valid        = '0;
    wb_pd           = '0;
    issue_ready     = '0;
    flush_valid     = 1'b0;
    recover_valid   = 1'b0;
    recover_rob_idx = '0;
    recover_epoch   = cur_epoch;
  endtask

  // Called just after a rising edge with inputs driven; compares at the falling
  // edge, advances the model, and returns just after the next rising edge.
  task automatic step();
    int      sel [FU_NUM];
    int      df;
    logic    exp_dr, exp_busy;
    rs_uop_t u;
    rs_uop_t nq[$];
    @(negedge clk);
    df       = int'(uop_to_fu(disp_uop.bundle.uop_class));
    exp_dr   = !flush_valid && !recover_valid && (mq[df].size() < DEPTH);
    exp_busy = 1'b0;
    for (int f = 0; f < FU_NUM; f++) begin
      sel[f] = -1;
      for (int i = 0; i < mq[f].size(); i++)
        if (sel[f] < 0 && is_ready(mq[f][i]) && !squashed(mq[f][i])) sel[f] = i;
      if (mq[f].size() != 0) exp_busy = 1'b1;
    end
    check_val("disp_ready", 64'(disp_ready), 64'(exp_dr));
    check_val("busy", 64'(busy), 64'(exp_busy));
    for (int f = 0; f < FU_NUM; f++) begin
      check_val($sformatf("occupancy[%0d]", f), 64'(occupancy[f]), 64'(mq[f].size()));
      check_val($sformatf("issue_valid[%0d]", f), 64'(issue_valid[f]), 64'(sel[f] >= 0));
      if (sel[f] >= 0) begin
        u      = mq[f][sel[f]];
        u.rdy1 = 1'b1;
        u.rdy2 = 1'b1;
        check_val($sformatf("issue_uop[%0d]", f), 64'(issue_uop[f]), 64'(u));
      end
    end
    if (flush_valid) begin
      for (int f = 0; f < FU_NUM; f++) mq[f].delete();
    end else begin
      for (int f = 0; f < FU_NUM; f++) begin
        nq.delete();
        for (int i = 0; i < mq[f].size(); i++) begin
          if (!(i == sel[f] && issue_ready[f]) && !squashed(mq[f][i])) begin
            u = mq[f][i];
            if (hit(u.prs1)) u.rdy1 = 1'b1;
            if (hit(u.prs2)) u.rdy2 = 1'b1;
            nq.push_back(u);
          end
        end
        mq[f] = nq;
      end
      if (disp_valid && exp_dr) begin
        u = disp_uop;
        if (!u.uses_rs1 || hit(u.prs1)) u.rdy1 = 1'b1;
        if (!u.uses_rs2 || hit(u.prs2)) u.rdy2 = 1'b1;
        mq[df].push_back(u);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input rs_uop_t u);
    disp_valid = 1'b1;
    disp_uop   = u;
    step();
    disp_valid = 1'b0;
  endtask

  rs_uop_t ru;

  initial begin
    rst_n    = 1'b0;
    rob_head = '0;
    idle();
    @(posedge clk);
    #1;
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_issue_valid", 64'(issue_valid), 64'(0));
    check_val("rst_disp_ready", 64'(disp_ready), 64'(1));
    step();
    rst_n = 1'b1;
    step();

    // Fill the ALU queue, then drain it in age order.
    for (int k = 1; k <= 4; k++) disp(mk(int'(UC_INT), k, 1, 1'b1, 2, 1'b1));
    #1;
    check_val("full_occ", 64'(occupancy[ALU]), 64'(4));
    disp_valid     = 1'b1;
    disp_uop       = mk(int'(UC_INT), 9, 1, 1'b1, 2, 1'b1);
    issue_ready[ALU] = 1'b1;
    #1;
    check_val("full_disp_ready", 64'(disp_ready), 64'(0));
    check_val("drain_rob1", 64'(issue_uop[ALU].rob_idx), 64'(1));
    step();
    disp_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      #1;
      check_val($sformatf("drain_rob%0d", k), 64'(issue_uop[ALU].rob_idx), 64'(k));
      step();
    end
    #1;
    check_val("drained", 64'(issue_valid[ALU]), 64'(0));

    // Older non-ready uop is overtaken, then released by a port-1 wakeup.
    issue_ready = '0;
    disp(mk(int'(UC_INT), 5, 20, 1'b0, 3, 1'b1));
    disp(mk(int'(UC_INT), 6, 4, 1'b1, 5, 1'b1));
    issue_ready[ALU] = 1'b1;
    #1;
    check_val("young_first", 64'(issue_uop[ALU].rob_idx), 64'(6));
    step();
    #1;
    check_val("wait_wakeup", 64'(issue_valid[ALU]), 64'(0));
    wb_valid[1] = 1'b1;
    wb_pd[1]    = PHYS_W'(20);
    #1;
    check_val("no_same_cycle", 64'(issue_valid[ALU]), 64'(0));
    step();
    idle();
    issue_ready[ALU] = 1'b1;
    #1;
    check_val("woken_rob5", 64'(issue_uop[ALU].rob_idx), 64'(5));
    check_val("woken_rdy1", 64'(issue_uop[ALU].rdy1), 64'(1));
    step();

    // Dispatch bypass on port 0.
    idle();
    wb_valid[0] = 1'b1;
    wb_pd[0]    = PHYS_W'(33);
    disp(mk(int'(UC_MUL), 7, 8, 1'b1, 33, 1'b0));
    idle();
    #1;
    check_val("bypass_valid", 64'(issue_valid[MUL]), 64'(1));
    check_val("bypass_rob", 64'(issue_uop[MUL].rob_idx), 64'(7));
    issue_ready[MUL] = 1'b1;
    step();
    idle();

    // Recovery across ROB wrap.
    rob_head = ROB_W'(14);
    disp(mk(int'(UC_INT), 14, 40, 1'b0, 1, 1'b1));
    disp(mk(int'(UC_INT), 15, 41, 1'b0, 1, 1'b1));
    disp(mk(int'(UC_INT), 0, 1, 1'b1, 1, 1'b1));
    disp(mk(int'(UC_INT), 1, 1, 1'b1, 1, 1'b1));
    recover_valid    = 1'b1;
    recover_rob_idx  = ROB_W'(15);
    recover_epoch    = cur_epoch;
    issue_ready[ALU] = 1'b1;
    #1;
    check_val("recover_mask", 64'(issue_valid[ALU]), 64'(0));
    check_val("recover_disp_ready", 64'(disp_ready), 64'(0));
    step();
    idle();
    #1;
    check_val("recover_occ", 64'(occupancy[ALU]), 64'(2));
    wb_valid = 2'b11;
    wb_pd[0] = PHYS_W'(40);
    wb_pd[1] = PHYS_W'(41);
    step();
    idle();
    issue_ready[ALU] = 1'b1;
    #1;
    check_val("recover_age0", 64'(issue_uop[ALU].rob_idx), 64'(14));
    step();
    #1;
    check_val("recover_age1", 64'(issue_uop[ALU].rob_idx), 64'(15));
    step();
    idle();

    // Flush beats dispatch and wakeup in the same cycle.
    disp(mk(int'(UC_INT), 2, 1, 1'b1, 1, 1'b1));
    disp(mk(int'(UC_MUL), 3, 50, 1'b0, 1, 1'b1));
    flush_valid = 1'b1;
    wb_valid[0] = 1'b1;
    wb_pd[0]    = PHYS_W'(50);
    disp(mk(int'(UC_INT), 4, 1, 1'b1, 1, 1'b1));
    idle();
    #1;
    check_val("flush_busy", 64'(busy), 64'(0));
    for (int f = 0; f < FU_NUM; f++)
      check_val($sformatf("flush_occ[%0d]", f), 64'(occupancy[f]), 64'(0));

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 3; k++) disp(mk(int'(UC_INT), 8 + k, 1, 1'b1, 1, 1'b1));
    #1;
    check_val("prereset_valid", 64'(issue_valid[ALU]), 64'(1));
    rst_n = 1'b0;
    #1;
    check_val("async_busy", 64'(busy), 64'(0));
    check_val("async_issue_valid", 64'(issue_valid), 64'(0));
    check_val("async_occ", 64'(occupancy[ALU]), 64'(0));
    for (int f = 0; f < FU_NUM; f++) mq[f].delete();
    step();
    rst_n = 1'b1;
    disp(mk(int'(UC_INT), 12, 1, 1'b1, 1, 1'b1));
    #1;
    check_val("post_reset_occ", 64'(occupancy[ALU]), 64'(1));
    idle();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      disp_valid = ($urandom_range(0, 99) < 60);
      ru = mk(int'($urandom_range(0, 5)), int'(rob_ctr), int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      ru.uses_rs1 = 1'($urandom_range(0, 1));
      ru.uses_rs2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ru.epoch = cur_epoch + 1'b1;
      disp_uop = ru;
      if (disp_valid) rob_ctr++;
      wb_valid = WB_PORTS'($urandom);
      for (int p = 0; p < WB_PORTS; p++) wb_pd[p] = PHYS_W'($urandom_range(0, 15));
      issue_ready     = FU_NUM'($urandom);
      rob_head        = rob_ctr - ROB_W'(12);
      recover_valid   = ($urandom_range(0, 99) < 4);
      recover_rob_idx = rob_head + ROB_W'($urandom_range(0, 11));
      recover_epoch   = cur_epoch;
      if (recover_valid && ($urandom_range(0, 3) == 0)) begin
        cur_epoch++;
        recover_epoch = cur_epoch;
      end
      flush_valid = ($urandom_range(0, 99) < 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_multi.md
# rs_multi

Parametrised, multi-entry reservation station that holds dispatched uops per functional unit until their source operands are ready, then issues the oldest ready uop to each FU. It sits between rename/dispatch and the FU array and snoops multiple CDB writeback ports for wakeup. It supersedes the fixed two-slot RS with configurable depth, multiple wakeup ports, dispatch-time wakeup bypass and age-based (younger-than) recovery squash.

## Interface
- DEPTH, 4: entries per FU queue; ≥2; AGE_W = $clog2(DEPTH)
- WB_PORTS, 2: number of CDB wakeup ports
- FU_NUM, PHYS_W, ROB_W, EPOCH_W: global values from defines.svh; `rs_uop_t`, `fu_e` and `uop_to_fu()` also from defines.svh
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- disp_valid  input  1  dispatch request
- disp_ready  output  1  target FU queue has a free entry, and no flush/recover this cycle
- disp_uop  input  rs_uop_t  uop to enqueue; FU is selected by uop_to_fu(disp_uop.bundle.uop_class)
- wb_valid  input  [WB_PORTS]  CDB writeback valid, one per port
- wb_pd  input  [WB_PORTS][PHYS_W]  written physical register, one per port
- issue_valid  output  [FU_NUM]  ready uop presented to FU f
- issue_ready  input  [FU_NUM]  FU f accepts
- issue_uop  output  rs_uop_t [FU_NUM]  presented uop, with rdy1/rdy2 forced to 1
- rob_head  input  ROB_W  current ROB head index; reference point for age
- flush_valid  input  1  drop all entries
- recover_valid  input  1  squash entries younger than recover_rob_idx
- recover_rob_idx  input  ROB_W  mispredicting uop's ROB index
- recover_epoch  input  EPOCH_W  epoch of the surviving path
- busy  output  1  any entry valid in any queue
- occupancy  output  [FU_NUM][AGE_W+1]  valid-entry count per FU

## Operation
- Storage: FU_NUM queues of DEPTH entries. Each entry holds {valid, uop, age}. age is unsigned AGE_W; 0 = oldest. Within a queue, ages of valid entries are unique and contiguous, 0..occupancy-1.
- Dispatch: fires on disp_valid && disp_ready. The uop goes into the lowest-index free entry of the target queue, with age = occupancy after issue/squash removals of the same cycle.
- Dispatch bypass: if uses_rs1 and prs1 matches any wb_pd[p] with wb_valid[p] in the same cycle, store rdy1=1. Same rule for rs2. A source that is not used is stored with its rdy set to 1.
- Wakeup: for every valid entry and every port p with wb_valid[p], set rdy1 if prs1==wb_pd[p], and rdy2 if prs2==wb_pd[p]. Takes effect next cycle; there is no same-cycle wakeup-to-issue path.
- Ready means valid && (!uses_rs1 || rdy1) && (!uses_rs2 || rdy2).
- Select: per FU, the ready entry with the smallest age. issue_valid[f] = any ready entry, excluding entries being squashed this cycle.
- Issue consume: on issue_valid[f] && issue_ready[f], clear the selected entry. Every remaining entry in that queue with a larger age decrements its age by 1.
- Recovery: rel(x) = (x - rob_head) mod 2^ROB_W. Squash entry e when rel(e.rob_idx) > rel(recover_rob_idx), or when e.epoch != recover_epoch. The recovering uop itself survives. Squash compacts ages: new age = count of surviving older entries.
- Flush: all valid bits cleared. Has priority over recover, wakeup, dispatch and issue in the same cycle.
- Same-queue issue and dispatch in one cycle: both happen. The freed entry is not reused until the next cycle. Age arithmetic applies the issue decrement first, then appends the new entry.
- busy = OR of all valid bits. occupancy[f] = popcount of queue f valid bits.

## Timing
- Reset (async): all valid=0, all ages=0. Resulting outputs: issue_valid=0, busy=0, occupancy=0, disp_ready=1 whenever flush_valid=0 and recover_valid=0.
- disp_ready is combinational from queue state, flush_valid and recover_valid. It is low when the target queue is full (occupancy==DEPTH), in any flush cycle and in any recover cycle; dispatch in those cycles is dropped.
- issue_valid/issue_uop are combinational from registered state and recover inputs. issue_valid does not depend on issue_ready.
- Latency: a dispatched uop that is ready (including via bypass) can issue the cycle after dispatch. A wakeup at cycle t allows issue at t+1.
- Full queue + issue in the same cycle: disp_ready stays 0 that cycle (no same-cycle reuse).
- ROB index wrap: age comparison uses rel(), so it is correct across wrap while the ROB holds fewer than 2^ROB_W entries.
- rst_n asserted mid-operation: all state clears immediately. Outputs take their reset values before the next clk edge.

## Test plan
- DEPTH=4, ALU queue: dispatch 4 ready uops (rob 1,2,3,4) with issue_ready=0 -> occupancy[ALU]=4, disp_ready=0 for an ALU uop; then issue_ready=1 -> issues rob 1,2,3,4 in consecutive cycles.
- Dispatch rob 5 (prs1=20 not ready), then rob 6 (ready) -> rob 6 issues first. wb_pd[1]=20 at cycle t -> rob 5 issues at t+1 with rdy1=1.
- Dispatch a uop with prs2=33 in the same cycle as wb_valid[0], wb_pd[0]=33 -> stored with rdy2=1, issue_valid high next cycle.
- rob_head=14, ROB_W=4, entries rob 14,15,0,1; recover_rob_idx=15 -> rob 0 and 1 squashed, 14 and 15 kept, ages 0 and 1; issue_valid masked for the squashed entries in the recover cycle.
- flush_valid with dispatch and wakeup in the same cycle -> all queues empty next cycle, busy=0, dispatched uop absent.
- Assert rst_n low mid-stream with 3 valid entries -> issue_valid=0 and busy=0 before the next edge; after release, dispatch accepted.
